stream_arbiter: RTL and testbench



---
 rtl/stream_arbiter_if.sv | 28 ++
 rtl/stream_arbiter.sv | 185 ++++++++++++++++++
 tb/tb_stream_arbiter.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/stream_arbiter_if.sv
// stream_channel: AXI-Stream style channel bundle shared by stream_arbiter and its neighbours.
// The master modport drives payload and t_valid; the slave modport returns t_ready.
interface stream_channel #(
    parameter int DATA_W = 8,
    parameter int ID_W   = 4,
    parameter int DEST_W = 4,
    parameter int USER_W = 1
);
    logic [ID_W-1:0]     t_id;
    logic [DEST_W-1:0]   t_dest;
    logic [DATA_W-1:0]   t_data;
    logic [DATA_W/8-1:0] t_strb;
    logic [DATA_W/8-1:0] t_keep;
    logic                t_last;
    logic [USER_W-1:0]   t_user;
    logic                t_valid;
    logic                t_ready;

    modport master (
        output t_id, t_dest, t_data, t_strb, t_keep, t_last, t_user, t_valid,
        input  t_ready
    );

    modport slave (
        input  t_id, t_dest, t_data, t_strb, t_keep, t_last, t_user, t_valid,
        output t_ready
    );
endinterface

// File: rtl/stream_arbiter.sv
// stream_arbiter: packet-level round-robin arbiter sharing one downstream stream
// channel between NUM_MASTERS upstream channels. A grant is held from arbitration
// until the granted master's t_last beat is accepted, so packets never interleave.
// Optional build macro STREAM_ARBITER_OUTPUT_REG_EN: inserts a 2-entry skid buffer
// that registers every downstream output; release then happens when t_last enters
// the skid buffer. Without the macro the data path is a purely combinational mux.
module stream_arbiter #(
    parameter int NUM_MASTERS = 2,
    parameter int DATA_W      = 8,
    parameter int ID_W        = 4,
    parameter int DEST_W      = 4,
    parameter int USER_W      = 1
) (
    input  logic          clk,
    input  logic          rst,
    stream_channel.slave  master [NUM_MASTERS],
    stream_channel.master slave
);
    localparam int IDX_W  = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam int STRB_W = DATA_W / 8;
    localparam int PAY_W  = ID_W + DEST_W + DATA_W + 2 * STRB_W + USER_W + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_MASTERS - 1);

    typedef enum logic {
        IDLE,
        LOCKED
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [IDX_W-1:0] g_q;
    logic [IDX_W-1:0] g_d;
    logic [IDX_W-1:0] rr_q;
    logic [IDX_W-1:0] rr_d;

    logic [NUM_MASTERS-1:0] m_valid;
    logic [NUM_MASTERS-1:0] m_ready;
    logic [PAY_W-1:0]       m_pay [NUM_MASTERS];

    logic             mux_valid;
    logic             mux_ready;
    logic [PAY_W-1:0] mux_pay;
    logic             mux_last;
    logic             release_pkt;

    logic             pick_found;
    logic [IDX_W-1:0] pick_idx;

    logic             out_valid;
    logic [PAY_W-1:0] out_pay;

    // Flatten the interface array so the grant index can select a channel.
    // The payload is packed with t_last in bit 0.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_MASTERS; gi++) begin : g_in
            assign m_valid[gi] = master[gi].t_valid;
            assign m_pay[gi]   = {master[gi].t_id, master[gi].t_dest, master[gi].t_data,
                                  master[gi].t_strb, master[gi].t_keep, master[gi].t_user,
                                  master[gi].t_last};
            assign master[gi].t_ready = m_ready[gi];
        end
    endgenerate

    assign mux_last    = mux_pay[0];
    assign release_pkt = mux_valid & mux_ready & mux_last;

    // State register: FSM state, current grant and round-robin start pointer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            g_q     <= '0;
            rr_q    <= '0;
        end else begin
            state_q <= state_d;
            g_q     <= g_d;
            rr_q    <= rr_d;
        end
    end

    // Next state: pick the first valid master scanning from rr, release on accepted t_last.
    always_comb begin : next_state
        int scan;
        state_d    = state_q;
        g_d        = g_q;
        rr_d       = rr_q;
        pick_found = 1'b0;
        pick_idx   = '0;
        scan       = 0;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            scan = int'(rr_q) + k;
            if (scan >= NUM_MASTERS) begin
                scan = scan - NUM_MASTERS;
            end
            for (int j = 0; j < NUM_MASTERS; j++) begin
                if (!pick_found && (scan == j) && m_valid[j]) begin
                    pick_found = 1'b1;
                    pick_idx   = IDX_W'(j);
                end
            end
        end
        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    state_d = LOCKED;
                    g_d     = pick_idx;
                end
            end
            LOCKED: begin
                if (release_pkt) begin
                    state_d = IDLE;
                    rr_d    = (g_q == LAST_IDX) ? '0 : g_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs: route the granted master to the mux; t_ready never depends on any t_valid.
    always_comb begin
        m_ready   = '0;
        mux_valid = 1'b0;
        mux_pay   = '0;
        if (state_q == LOCKED) begin
            for (int k = 0; k < NUM_MASTERS; k++) begin
                if (g_q == IDX_W'(k)) begin
                    mux_valid  = m_valid[k];
                    mux_pay    = m_pay[k];
                    m_ready[k] = mux_ready;
                end
            end
        end
    end

`ifdef STREAM_ARBITER_OUTPUT_REG_EN
    logic             head_valid_q;
    logic [PAY_W-1:0] head_pay_q;
    logic             skid_valid_q;
    logic [PAY_W-1:0] skid_pay_q;
    logic             push;
    logic             pop;

    assign mux_ready = ~(head_valid_q & skid_valid_q);
    assign push      = mux_valid & mux_ready;
    assign pop       = head_valid_q & slave.t_ready;
    assign out_valid = head_valid_q;
    assign out_pay   = head_pay_q;

    // Skid buffer: head register feeds the slave, spare entry absorbs a beat during a stall.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_valid_q <= 1'b0;
            head_pay_q   <= '0;
            skid_valid_q <= 1'b0;
            skid_pay_q   <= '0;
        end else begin
            if (!head_valid_q || pop) begin
                if (skid_valid_q) begin
                    head_valid_q <= 1'b1;
                    head_pay_q   <= skid_pay_q;
                    skid_valid_q <= push;
                    if (push) begin
                        skid_pay_q <= mux_pay;
                    end
                end else begin
                    head_valid_q <= push;
                    head_pay_q   <= push ? mux_pay : '0;
                end
            end else if (push) begin
                skid_valid_q <= 1'b1;
                skid_pay_q   <= mux_pay;
            end
        end
    end
`else
    assign mux_ready = slave.t_ready;
    assign out_valid = mux_valid;
    assign out_pay   = mux_pay;
`endif

    assign slave.t_valid = out_valid;
    assign {slave.t_id, slave.t_dest, slave.t_data, slave.t_strb, slave.t_keep,
            slave.t_user, slave.t_last} = out_pay;

endmodule

// File: tb/tb_stream_arbiter.sv
// tb_stream_arbiter: directed bench for stream_arbiter with four upstream masters.
// Each master is a small beat list with optional start delay and valid gap; slave beats
// are captured with their cycle number and compared against hand-computed tables.
module tb_stream_arbiter;
    localparam int NM = 4;
`ifdef STREAM_ARBITER_OUTPUT_REG_EN
    localparam int EXTRA = 1;
`else
    localparam int EXTRA = 0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic s_ready;

    logic       tb_valid [NM];
    logic [7:0] tb_data  [NM];
    logic       tb_last  [NM];
    logic       tb_ready [NM];

    stream_channel m_if [NM] ();
    stream_channel s_if ();

    stream_arbiter #(.NUM_MASTERS(NM)) dut (
        .clk    (clk),
        .rst    (rst),
        .master (m_if),
        .slave  (s_if)
    );

    genvar gi;
    generate
        for (gi = 0; gi < NM; gi++) begin : g_drv
            assign m_if[gi].t_valid = tb_valid[gi];
            assign m_if[gi].t_data  = tb_data[gi];
            assign m_if[gi].t_last  = tb_last[gi];
            assign m_if[gi].t_id    = 4'(gi);
            assign m_if[gi].t_dest  = 4'hA;
            assign m_if[gi].t_strb  = 1'b1;
            assign m_if[gi].t_keep  = 1'b1;
            assign m_if[gi].t_user  = 1'b0;
            assign tb_ready[gi]     = m_if[gi].t_ready;
        end
    endgenerate
    assign s_if.t_ready = s_ready;

    // Free-running clock, period 10.
    always #5 clk = ~clk;

    logic [7:0]  beat_data [NM][16];
    logic        beat_last [NM][16];
    int          beat_cnt  [NM];
    int          beat_ptr  [NM];
    int          start_cyc [NM];
    int          gap_at    [NM];
    int          gap_len   [NM];
    int          gap_rem   [NM];
    logic [15:0] ready_pat;
    int          ready_len;
    int          cyc;

    logic [12:0] cap_beat [64];
    int          cap_cyc  [64];
    int          cap_n;
    logic [12:0] exp_beat [64];
    int          exp_cyc  [64];
    int          exp_n;

    int   m0_ready_cnt;
    int   m1_early_cnt;
    int   mirror_err;
    logic m0_done;

    int tests_run    = 0;
    int tests_failed = 0;

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    task automatic clearModel();
        for (int i = 0; i < NM; i++) begin
            beat_cnt[i]  = 0;
            beat_ptr[i]  = 0;
            start_cyc[i] = 0;
            gap_at[i]    = -1;
            gap_len[i]   = 0;
            gap_rem[i]   = 0;
        end
        ready_pat    = 16'h0000;
        ready_len    = 0;
        cyc          = 0;
        cap_n        = 0;
        exp_n        = 0;
        m0_ready_cnt = 0;
        m1_early_cnt = 0;
        mirror_err   = 0;
        m0_done      = 1'b0;
    endtask

    task automatic loadPacket(input int m, input logic [7:0] first, input int nbeats);
        for (int b = 0; b < nbeats; b++) begin
            beat_data[m][beat_cnt[m]] = first + 8'(b);
            beat_last[m][beat_cnt[m]] = (b == nbeats - 1);
            beat_cnt[m]++;
        end
    endtask

    task automatic expBeat(input logic [7:0] d, input int id, input logic last, input int c);
        exp_beat[exp_n] = {last, 4'(id), d};
        exp_cyc[exp_n]  = c + EXTRA;
        exp_n++;
    endtask

    task automatic applyStimulus();
        for (int i = 0; i < NM; i++) begin
            tb_valid[i] = (cyc >= start_cyc[i]) && (beat_ptr[i] < beat_cnt[i]) && (gap_rem[i] == 0);
            tb_data[i]  = tb_valid[i] ? beat_data[i][beat_ptr[i]] : 8'h00;
            tb_last[i]  = tb_valid[i] ? beat_last[i][beat_ptr[i]] : 1'b0;
        end
        s_ready = (cyc < ready_len) ? ready_pat[4'(cyc)] : 1'b1;
    endtask

    task automatic stepCycle();
        applyStimulus();
        @(negedge clk);
        if (s_if.t_valid && s_ready) begin
            if (cap_n < 64) begin
                cap_beat[cap_n] = {s_if.t_last, s_if.t_id, s_if.t_data};
                cap_cyc[cap_n]  = cyc;
            end
            cap_n++;
        end
        if (tb_ready[0]) m0_ready_cnt++;
        if (tb_ready[1] && !m0_done) m1_early_cnt++;
        if (cyc >= 1 && !m0_done && tb_ready[0] !== s_ready) mirror_err++;
        for (int i = 0; i < NM; i++) begin
            if (tb_valid[i] && tb_ready[i]) begin
                if (i == 0 && tb_last[0]) m0_done = 1'b1;
                if (gap_at[i] == beat_ptr[i]) gap_rem[i] = gap_len[i];
                beat_ptr[i]++;
            end else if (gap_rem[i] > 0) begin
                gap_rem[i]--;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic resetDut();
        rst = 1'b1;
        applyStimulus();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic compareBeats(input string tag, input bit with_cyc);
        checkOutput({tag, " count"}, cap_n, exp_n);
        for (int k = 0; k < exp_n; k++) begin
            if (k < cap_n && k < 64) begin
                checkOutput($sformatf("%s beat%0d", tag, k), cap_beat[k], exp_beat[k]);
                if (with_cyc) begin
                    checkOutput($sformatf("%s cycle%0d", tag, k), cap_cyc[k], exp_cyc[k]);
                end
            end
        end
    endtask

    initial begin
        // Reset state: nothing valid, all readies low, payload zero.
        clearModel();
        rst = 1'b1;
        applyStimulus();
        #2;
        checkOutput("reset s_valid", s_if.t_valid, 0);
        checkOutput("reset s_data", s_if.t_data, 0);
        checkOutput("reset s_last", s_if.t_last, 0);
        checkOutput("reset m_ready", {tb_ready[3], tb_ready[2], tb_ready[1], tb_ready[0]}, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Single requester: master 1 sends A1,A2,A3 after one arbitration bubble.
        clearModel();
        resetDut();
        loadPacket(1, 8'hA1, 3);
        expBeat(8'hA1, 1, 1'b0, 1);
        expBeat(8'hA2, 1, 1'b0, 2);
        expBeat(8'hA3, 1, 1'b1, 3);
        repeat (8) stepCycle();
        compareBeats("single", 1'b1);
        checkOutput("single m0 ready", m0_ready_cnt, 0);

        // Round robin: all four masters hold two 2-beat packets each.
        clearModel();
        resetDut();
        for (int m = 0; m < NM; m++) begin
            loadPacket(m, 8'(m * 16 + 1), 2);
            loadPacket(m, 8'(m * 16 + 3), 2);
        end
        for (int p = 0; p < 8; p++) begin
            expBeat(8'((p % 4) * 16 + (p / 4) * 2 + 1), p % 4, 1'b0, 3 * p + 1);
            expBeat(8'((p % 4) * 16 + (p / 4) * 2 + 2), p % 4, 1'b1, 3 * p + 2);
        end
        repeat (28) stepCycle();
        compareBeats("rr", 1'b1);

        // Backpressure: master 0 4-beat packet while master 1 waits; ready 1,0,0,1,1,0,1.
        clearModel();
        resetDut();
        loadPacket(0, 8'hB0, 4);
        loadPacket(1, 8'hC0, 1);
        ready_pat = 16'h00B3;
        ready_len = 8;
        expBeat(8'hB0, 0, 1'b0, 1);
        expBeat(8'hB1, 0, 1'b0, 4);
        expBeat(8'hB2, 0, 1'b0, 5);
        expBeat(8'hB3, 0, 1'b1, 7);
        expBeat(8'hC0, 1, 1'b1, 9);
        repeat (16) stepCycle();
`ifdef STREAM_ARBITER_OUTPUT_REG_EN
        compareBeats("bp", 1'b0);
`else
        compareBeats("bp", 1'b1);
        checkOutput("bp m0 ready mirror", mirror_err, 0);
`endif
        checkOutput("bp m1 early ready", m1_early_cnt, 0);

        // Valid gap: master 2 pauses 3 cycles after beat 0; master 0 must wait for its t_last.
        clearModel();
        resetDut();
        loadPacket(2, 8'hD0, 3);
        gap_at[2]    = 0;
        gap_len[2]   = 3;
        loadPacket(0, 8'hE0, 2);
        start_cyc[0] = 1;
        expBeat(8'hD0, 2, 1'b0, 1);
        expBeat(8'hD1, 2, 1'b0, 5);
        expBeat(8'hD2, 2, 1'b1, 6);
        expBeat(8'hE0, 0, 1'b0, 8);
        expBeat(8'hE1, 0, 1'b1, 9);
        repeat (14) stepCycle();
        compareBeats("gap", 1'b1);

        // Reset mid-packet: rr is 2 before reset, so a surviving rr would pick master 3 first.
        clearModel();
        resetDut();
        loadPacket(1, 8'h11, 1);
        loadPacket(0, 8'h01, 4);
        start_cyc[0] = 2;
        repeat (4) stepCycle();
        applyStimulus();
        #2;
        rst = 1'b1;
        #1;
        checkOutput("midrst s_valid", s_if.t_valid, 0);
        checkOutput("midrst m_ready", {tb_ready[3], tb_ready[2], tb_ready[1], tb_ready[0]}, 0);
        clearModel();
        loadPacket(1, 8'h21, 1);
        loadPacket(3, 8'h23, 1);
        applyStimulus();
        @(posedge clk);
        #1;
        rst = 1'b0;
        expBeat(8'h21, 1, 1'b1, 1);
        expBeat(8'h23, 3, 1'b1, 3);
        repeat (8) stepCycle();
        compareBeats("postrst", 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    // Guard against a stuck run.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
